// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: turns single-beat command requests into one AXI-Lite
// write or read at a time, with a per-transaction timeout for forward progress.
`timescale 1ns/1ps

module axi_lite_master #(
    parameter int DATA_W      = 32,
    parameter int STRB_W      = 4,
    parameter int ADDR_W      = 4,
    parameter int TXN_TIMEOUT = 50
) (
    input  logic              clk,
    input  logic              arst_n,
    // command side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    // response side
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_tmo,
    // AXI-Lite write channels
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    // AXI-Lite read channels
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    // state  | meaning
    // IDLE   | cmd_ready high, waiting for a command
    // WR_REQ | awvalid/wvalid presented, waiting for both handshakes
    // WR_RSP | bready high, waiting for bvalid
    // RD_REQ | arvalid presented, waiting for arready
    // RD_RSP | rready high, waiting for rvalid
    // DONE   | rsp_valid high, held until rsp_ready
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int TMR_W = $clog2(TXN_TIMEOUT);
    // Down-counter loaded at accept; reaching zero marks the last cycle in
    // which a completing handshake can still be honoured.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TXN_TIMEOUT - 2);

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic              expired;
    logic              tmo_hit;
    logic              aw_done, w_done;

    logic              cmd_ready_nxt;
    logic              awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic [ADDR_W-1:0] awaddr_nxt, araddr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [STRB_W-1:0] wstrb_nxt;
    logic              rsp_valid_nxt, rsp_tmo_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic [1:0]        rsp_resp_nxt;

    assign expired = (tmr == '0);
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid || wready;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            cmd_ready <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= '0;
            araddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            rsp_tmo   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            cmd_ready <= cmd_ready_nxt;
            awvalid   <= awvalid_nxt;
            wvalid    <= wvalid_nxt;
            bready    <= bready_nxt;
            arvalid   <= arvalid_nxt;
            rready    <= rready_nxt;
            awaddr    <= awaddr_nxt;
            araddr    <= araddr_nxt;
            wdata     <= wdata_nxt;
            wstrb     <= wstrb_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_resp  <= rsp_resp_nxt;
            rsp_tmo   <= rsp_tmo_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        tmr_nxt       = expired ? tmr : tmr - TMR_W'(1);
        tmo_hit       = 1'b0;
        awvalid_nxt   = awvalid;
        wvalid_nxt    = wvalid;
        bready_nxt    = bready;
        arvalid_nxt   = arvalid;
        rready_nxt    = rready;
        awaddr_nxt    = awaddr;
        araddr_nxt    = araddr;
        wdata_nxt     = wdata;
        wstrb_nxt     = wstrb;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_resp_nxt  = rsp_resp;
        rsp_tmo_nxt   = rsp_tmo;

        case (state)
            IDLE: begin
                tmr_nxt = tmr;
                if (cmd_valid && cmd_ready) begin
                    tmr_nxt = TMR_LOAD;
                    if (cmd_write) begin
                        awaddr_nxt  = cmd_addr;
                        wdata_nxt   = cmd_wdata;
                        wstrb_nxt   = cmd_wstrb;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = WR_REQ;
                    end else begin
                        araddr_nxt  = cmd_addr;
                        arvalid_nxt = 1'b1;
                        state_nxt   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (expired) begin
                    tmo_hit = 1'b1;
                end else begin
                    awvalid_nxt = awvalid && !awready;
                    wvalid_nxt  = wvalid && !wready;
                    if (aw_done && w_done) begin
                        bready_nxt = 1'b1;
                        state_nxt  = WR_RSP;
                    end
                end
            end
            WR_RSP: begin
                // completion on the expiry cycle still counts as a normal response
                if (bvalid && bready) begin
                    bready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_resp_nxt  = bresp;
                    rsp_tmo_nxt   = 1'b0;
                    state_nxt     = DONE;
                end else if (expired) begin
                    tmo_hit = 1'b1;
                end
            end
            RD_REQ: begin
                if (expired) begin
                    tmo_hit = 1'b1;
                end else if (arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RD_RSP;
                end
            end
            RD_RSP: begin
                if (rvalid && rready) begin
                    rready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = rdata;
                    rsp_resp_nxt  = rresp;
                    rsp_tmo_nxt   = 1'b0;
                    state_nxt     = DONE;
                end else if (expired) begin
                    tmo_hit = 1'b1;
                end
            end
            DONE: begin
                tmr_nxt = tmr;
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    rsp_tmo_nxt   = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (tmo_hit) begin
            awvalid_nxt   = 1'b0;
            wvalid_nxt    = 1'b0;
            bready_nxt    = 1'b0;
            arvalid_nxt   = 1'b0;
            rready_nxt    = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = '0;
            rsp_resp_nxt  = 2'b10;
            rsp_tmo_nxt   = 1'b1;
            state_nxt     = DONE;
        end

        cmd_ready_nxt = (state_nxt == IDLE);
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a parameterised slave model drives the
// bus, a scoreboard queue holds expected responses, a monitor pops and checks.
`timescale 1ns/1ps

module tb_axi_lite_master;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int ADDR_W = 4;
    localparam int TXN_TIMEOUT = 50;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [STRB_W-1:0] cmd_wstrb = '0;
    logic              rsp_valid, rsp_ready = 1'b0, rsp_tmo;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic              awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [1:0]        bresp = 2'b00, rresp = 2'b00;
    logic              bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic [DATA_W-1:0] rdata = '0;
    logic              rvalid = 1'b0, rready;

    always #5 clk = ~clk;

    axi_lite_master #(
        .DATA_W(DATA_W), .STRB_W(STRB_W), .ADDR_W(ADDR_W), .TXN_TIMEOUT(TXN_TIMEOUT)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_tmo(rsp_tmo),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = '0;
    logic [3:0]  e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic [3:0]  e_wstrb = '0;
    int          cfg_gen = 0;

    int          seen_gen = 0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit          aw_done = 0, w_done = 0, wr_pend = 0, rd_pend = 0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cnt = 0;

    always @(negedge clk) begin
        if (!arst_n || seen_gen != cfg_gen) begin
            seen_gen = cfg_gen;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_done = 0; w_done = 0; wr_pend = 0; rd_pend = 0; b_hs_cnt = 0;
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            arready = 1'b0; rvalid = 1'b0; rdata = '0;
        end else begin
            bresp  = s_bresp;
            bvalid = wr_pend && (b_cnt >= b_dly);
            if (bvalid && bready) begin
                wr_pend = 0; b_cnt = 0; b_hs_cnt++;
            end else if (wr_pend) b_cnt++;

            awready = awvalid && (aw_cnt >= aw_dly);
            if (awvalid) begin
                if (awready) begin
                    check("awaddr", 64'(awaddr), 64'(e_addr));
                    aw_cnt = 0; aw_done = 1; aw_hs_cyc = cyc;
                end else aw_cnt++;
            end
            wready = wvalid && (w_cnt >= w_dly);
            if (wvalid) begin
                if (wready) begin
                    check("wdata_wstrb", {28'd0, wstrb, wdata}, {28'd0, e_wstrb, e_wdata});
                    w_cnt = 0; w_done = 1; w_hs_cyc = cyc;
                end else w_cnt++;
            end
            if (aw_done && w_done) begin
                wr_pend = 1; aw_done = 0; w_done = 0; b_cnt = 0;
            end

            rresp  = s_rresp;
            rvalid = rd_pend && (r_cnt >= r_dly);
            rdata  = rvalid ? s_rdata : '0;
            if (rvalid && rready) begin
                rd_pend = 0; r_cnt = 0;
            end else if (rd_pend) r_cnt++;

            arready = arvalid && (ar_cnt >= ar_dly);
            if (arvalid) begin
                if (arready) begin
                    check("araddr", 64'(araddr), 64'(e_addr));
                    ar_cnt = 0; rd_pend = 1; r_cnt = 0;
                end else ar_cnt++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          acc_cyc = 0, rise_cyc = 0, last_hs_cyc = 0, hold_cfg = 0, hold_cnt = 0;
    bit          prev_rv = 0, hold_prev = 0;
    logic [31:0] h_rdata = '0;
    logic [1:0]  h_resp = '0;
    logic        h_tmo = 1'b0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!arst_n) begin
            rsp_ready = 1'b0; prev_rv = 0; hold_prev = 0; hold_cnt = 0;
        end else begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (rsp_valid) begin
                if (hold_cnt < hold_cfg) begin
                    rsp_ready = 1'b0; hold_cnt++;
                end else rsp_ready = 1'b1;
            end else begin
                rsp_ready = 1'b0; hold_cnt = 0;
            end
            if (rsp_valid && !prev_rv) begin
                rise_cyc = cyc;
                check("bus_idle_at_rsp", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
            end
            if (rsp_valid && hold_prev)
                check("rsp_stable", {29'd0, rsp_rdata, rsp_resp, rsp_tmo}, {29'd0, h_rdata, h_resp, h_tmo});
            if (rsp_valid) check("cmd_ready_in_done", 64'(cmd_ready), 64'd0);
            if (rsp_valid && rsp_ready) begin
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got a response, want none (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                    check("rsp_resp", 64'(rsp_resp), 64'(mon_e.resp));
                    check("rsp_tmo", 64'(rsp_tmo), 64'(mon_e.tmo));
                    check("rsp_latency", 64'(rise_cyc - acc_cyc), 64'(mon_e.lat));
                end
            end
            hold_prev = rsp_valid && !rsp_ready;
            h_rdata = rsp_rdata; h_resp = rsp_resp; h_tmo = rsp_tmo;
            prev_rv = rsp_valid;
        end
    end

    // ---------------- driver ----------------
    task automatic slave_cfg(input int aw, input int w, input int b, input int ar, input int r,
                             input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
        @(posedge clk); #2;
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
        s_bresp = br; s_rresp = rr; s_rdata = rd;
        cfg_gen++;
    endtask

    task automatic send(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input bit push, input logic [31:0] x_rd,
                        input logic [1:0] x_rs, input logic x_tmo, input int x_lat, input bit keep);
        exp_t e;
        bit ok;
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        e_addr = addr; e_wdata = wd; e_wstrb = ws;
        if (push) begin
            e.rdata = x_rd; e.resp = x_rs; e.tmo = x_tmo; e.lat = x_lat;
            exp_q.push_back(e);
        end
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cmd_accept: got no accept in 200 cycles, want accept");
        end
        @(posedge clk); #2;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d responses pending after 300 cycles, want 0", name, exp_q.size());
        end
    endtask

    initial begin
        #1;
        check("rst_ctrl", 64'({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_tmo}), 64'd0);
        check("rst_bus", {20'd0, awaddr, araddr, wstrb, wdata}, 64'd0);
        check("rst_rsp", {30'd0, rsp_resp, rsp_rdata}, 64'd0);
        repeat (3) @(posedge clk);
        #2 arst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 64'(cmd_ready), 64'd1);

        // zero-wait write
        slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        send(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 1, 32'h0, 2'b00, 1'b0, 3, 0);
        wait_idle("wr_zero_wait");
        check("wr0_aw_hs_cycle", 64'(aw_hs_cyc - acc_cyc), 64'd1);
        check("wr0_b_hs_count", 64'(b_hs_cnt), 64'd1);

        // awready delayed 3 cycles, wready immediate
        slave_cfg(3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        send(1'b1, 4'h0, 32'h01234567, 4'hF, 1, 32'h0, 2'b00, 1'b0, 6, 0);
        wait_idle("wr_aw_delay");
        check("wr1_w_hs_cycle", 64'(w_hs_cyc - acc_cyc), 64'd1);
        check("wr1_aw_hs_cycle", 64'(aw_hs_cyc - acc_cyc), 64'd4);
        check("wr1_b_hs_count", 64'(b_hs_cnt), 64'd1);

        // wready delayed 2 cycles, slave returns bresp=01, partial strobe
        slave_cfg(0, 2, 0, 0, 0, 2'b01, 2'b00, 32'h0);
        send(1'b1, 4'hC, 32'h0000A5A5, 4'h3, 1, 32'h0, 2'b01, 1'b0, 5, 0);
        wait_idle("wr_w_delay");

        // read with 2 wait cycles on R, rresp=10
        slave_cfg(0, 0, 0, 0, 2, 2'b00, 2'b10, 32'h12345678);
        send(1'b0, 4'h8, 32'hFFFFFFFF, 4'hF, 1, 32'h12345678, 2'b10, 1'b0, 5, 0);
        wait_idle("rd_wait");

        // arready never: timeout
        slave_cfg(0, 0, 0, 1000, 0, 2'b00, 2'b00, 32'h77777777);
        send(1'b0, 4'h2, 32'h0, 4'h0, 1, 32'h0, 2'b10, 1'b1, 50, 0);
        wait_idle("rd_timeout");

        // rvalid on the last allowed cycle: completion wins
        slave_cfg(0, 0, 0, 0, 47, 2'b00, 2'b00, 32'hCAFEF00D);
        send(1'b0, 4'h6, 32'h0, 4'h0, 1, 32'hCAFEF00D, 2'b00, 1'b0, 50, 0);
        wait_idle("rd_edge_ok");

        // rvalid one cycle too late: timeout, late data ignored
        slave_cfg(0, 0, 0, 0, 48, 2'b00, 2'b00, 32'hCAFEF00D);
        send(1'b0, 4'h6, 32'h0, 4'h0, 1, 32'h0, 2'b10, 1'b1, 50, 0);
        wait_idle("rd_edge_tmo");

        // bvalid never: write timeout
        slave_cfg(0, 0, 1000, 0, 0, 2'b00, 2'b00, 32'h0);
        send(1'b1, 4'hA, 32'h5A5A5A5A, 4'hF, 1, 32'h0, 2'b10, 1'b1, 50, 0);
        wait_idle("wr_timeout");

        // response back-pressure for 5 cycles with the next command already waiting
        slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0BADC0DE);
        hold_cfg = 5;
        send(1'b1, 4'h1, 32'h11111111, 4'hF, 1, 32'h0, 2'b00, 1'b0, 3, 1);
        send(1'b0, 4'h3, 32'h0, 4'h0, 1, 32'h0BADC0DE, 2'b00, 1'b0, 3, 0);
        check("next_accept_after_rsp", 64'(acc_cyc - last_hs_cyc), 64'd1);
        wait_idle("backpressure");
        hold_cfg = 0;

        // reset while awvalid is high
        slave_cfg(1000, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        send(1'b1, 4'h5, 32'hFEEDFACE, 4'hF, 0, 32'h0, 2'b00, 1'b0, 0, 0);
        check("pre_rst_valids", 64'({awvalid, wvalid}), 64'd3);
        #1 arst_n = 1'b0;
        #1;
        check("rst_async_valids", 64'({awvalid, wvalid}), 64'd0);
        check("rst_async_rsp", 64'({rsp_valid, cmd_ready}), 64'd0);
        repeat (2) @(posedge clk);
        #2 arst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_mid_rst", 64'(cmd_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1 check("no_rsp_after_rst", 64'(rsp_valid), 64'd0);

        // recovery read
        slave_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h55AA55AA);
        send(1'b0, 4'h4, 32'h0, 4'h0, 1, 32'h55AA55AA, 2'b00, 1'b0, 3, 0);
        wait_idle("rd_recovery");

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us, want finish");
        $fatal(1, "watchdog");
    end

endmodule
